alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
- Upstream front end for the ALU on the FPGA board: turns raw board switches and push-buttons into clean, sequenced ALU operands and opcode.
- Synchronizes and debounces the buttons, then steps through operand A, operand B and opcode capture with an FSM.
- Issues a one-cycle operation strobe and latches the combinational ALU result and flags for the downstream hex-display logic.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable CLK cycles required before a button change is accepted (5 ms at 50 MHz); minimum 2.
SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.

Ports:
CLK  input  1  system clock; every flop is rising-edge.
nRST  input  1  asynchronous active-low reset.
sw_raw  input  18  raw board switches, asynchronous to CLK.
key_raw  input  4  raw push-buttons, active-low; [0]=advance, [1]=clear, [3:2] unused.
portA  output  32  operand A: captured SW[15:0], bits [31:16] replicated from SW[16].
portB  output  32  operand B: same format as portA.
aluop  output  4  opcode (aluop_t from cpu_types_pkg), captured from SW[3:0].
op_valid  output  1  one-cycle strobe in EXEC state.
alu_result  input  32  combinational ALU output.
alu_neg, alu_ovf, alu_zero  input  1 each  ALU flags.
result_q  output  32  latched ALU result, for display.
flags_q  output  3  latched {neg, ovf, zero}.
state_q  output  2  current FSM state encoding, for LED display.

Behaviour:
- Reset (nRST low, asynchronous): all outputs 0; state LOAD_A; synchronizer flops and debounced key values set to 1 (released); debounce counters 0.
- Synchronizers: each key_raw bit and each sw_raw bit passes through SYNC_STAGES flops. Switches are not debounced.
- Debounce, per key:
  - If the synchronized value differs from the debounced value, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the difference persists, the debounced value takes the new level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: a single-cycle pulse on a debounced 1->0 transition. Holding a key yields exactly one event; release yields none.
- Latency: a key press produces an event SYNC_STAGES+DEBOUNCE_CYCLES cycles after the raw edge, tolerance ±1 cycle.
- FSM states: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, plus SHOW. SHOW shares encoding 3 on state_q with op_valid=0; state_q is 2 bits and EXEC/SHOW are distinguished by op_valid.
  - LOAD_A: on advance, capture portA from synchronized SW; go to LOAD_B.
  - LOAD_B: on advance, capture portB; go to LOAD_OP.
  - LOAD_OP: on advance, capture aluop <= SW[3:0]; go to EXEC.
  - EXEC: lasts exactly 1 cycle with op_valid=1; at the end of that cycle, result_q and flags_q capture the ALU inputs; go to SHOW.
  - SHOW: hold all outputs; on advance, go to LOAD_A. portA, portB and aluop keep their values until overwritten.
- Clear event, in any state: go to LOAD_A; zero portA, portB, aluop, result_q and flags_q in the same edge.
- Clear and advance events in the same cycle: clear wins, and advance is discarded.
- Switch values are sampled on the cycle the advance event is high. Switch changes at other times have no effect.
- op_valid is never high for two consecutive cycles. The ALU is assumed combinational, so the result is valid in the EXEC cycle.
- key_raw[3:2] are synchronized but otherwise ignored.

Decomposition:
- cpu_types_pkg gains the FSM state typedef (seq_state_t) and the default debounce count constant.
- aluop_t is reused from cpu_types_pkg.
- One sub-module, key_debouncer (parameters DEBOUNCE_CYCLES, SYNC_STAGES), outputs the debounced level and a press pulse; it is instantiated twice (advance, clear).

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, ALU model in bench):
- Reset: hold nRST low with keys released -> all outputs 0, state_q=0; assert nRST low mid-sequence (state LOAD_OP) -> immediate return to state 0 and zeroed outputs without a clock edge.
- Full sequence: SW=0x1_0005 advance, SW=0x0_0003 advance, SW=ADD advance -> portA=0xFFFF0005, portB=0x00000003, op_valid pulses exactly one cycle, result_q=0xFFFF0008, flags_q neg=1; state SHOW.
- Bounce: advance toggled with 1-3 cycle pulses for 20 cycles, then held low 10 cycles -> exactly one advance event, state LOAD_A->LOAD_B only once; holding 100 cycles -> no further event.
- Overflow/zero: A=0x7FFF with SW[16]=0 (0x00007FFF) ... SUB of equal operands 0x1234-0x1234 -> result_q=0, zero=1, neg=0.
- Clear priority: clear and advance debounced in the same cycle in LOAD_B -> state LOAD_A, portA=0, portB unchanged at 0.
- Switch sampling: change SW every cycle between advance presses -> captured operand equals SW value on the event cycle only.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcode encoding, input-sequencer FSM states and
// the default debounce length for a 50 MHz board clock.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;

  // SHOW needs its own code internally; on the LED port it folds onto 3.
  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } seq_state_t;

  // 5 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 250000;

endpackage

// File: rtl/alu_input_sequencer_key_debouncer.sv
// Single push-button conditioner: synchronizer chain, stability counter,
// and a one-cycle pulse when the debounced level falls (key pressed).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   key_s;
  logic                   done;

  assign key_s = sync[SYNC_STAGES-1];
  // Difference has persisted for DEBOUNCE_CYCLES cycles including this one.
  assign done  = (key_s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press = done && level && !key_s;

  // Synchronizer chain, idles at "released".
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], key};
  end

  // Count consecutive cycles of disagreement; accept the new level when long enough.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (done) begin
      level <= key_s;
      cnt   <= '0;
    end else if (key_s != level) begin
      cnt   <= cnt + 1'b1;
    end else begin
      cnt   <= '0;
    end
  end

endmodule

// File: rtl/alu_input_sequencer.sv
// Board front end for the ALU: synchronizes switches, debounces the advance
// and clear buttons, and steps A -> B -> opcode -> execute -> show.
module alu_input_sequencer
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [17:0] sw_raw,
  input  logic [3:0]  key_raw,
  output logic [31:0] portA,
  output logic [31:0] portB,
  output aluop_t      aluop,
  output logic        op_valid,
  input  logic [31:0] alu_result,
  input  logic        alu_neg,
  input  logic        alu_ovf,
  input  logic        alu_zero,
  output logic [31:0] result_q,
  output logic [2:0]  flags_q,
  output logic [1:0]  state_q
);

  logic [SYNC_STAGES-1:0][17:0] sw_sync;
  logic [SYNC_STAGES-1:0][1:0]  spare_sync;
  logic [17:0]                  sw_s;
  logic [31:0]                  sw_ext;
  logic                         adv_evt, clr_evt, adv_lvl, clr_lvl;
  logic                         unused_bits;
  seq_state_t                   state, state_nxt;

  assign sw_s        = sw_sync[SYNC_STAGES-1];
  assign sw_ext      = {{16{sw_s[16]}}, sw_s[15:0]};
  // SW[17] and KEY[3:2] have no function on this board.
  assign unused_bits = ^{spare_sync[SYNC_STAGES-1], sw_s[17], adv_lvl, clr_lvl};

  // Switch and spare-key synchronizers; switches are level inputs, no debounce.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sw_sync    <= '1;
      spare_sync <= '1;
    end else begin
      sw_sync    <= {sw_sync[SYNC_STAGES-2:0], sw_raw};
      spare_sync <= {spare_sync[SYNC_STAGES-2:0], key_raw[3:2]};
    end
  end

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_adv (
    .CLK(CLK), .nRST(nRST), .key(key_raw[0]), .level(adv_lvl), .press(adv_evt)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clr (
    .CLK(CLK), .nRST(nRST), .key(key_raw[1]), .level(clr_lvl), .press(clr_evt)
  );

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ST_LOAD_A;
    else       state <= state_nxt;
  end

  // Next state; clear overrides any advance in the same cycle.
  always_comb begin
    state_nxt = state;
    if (clr_evt) state_nxt = ST_LOAD_A;
    else begin
      case (state)
        ST_LOAD_A:  if (adv_evt) state_nxt = ST_LOAD_B;
        ST_LOAD_B:  if (adv_evt) state_nxt = ST_LOAD_OP;
        ST_LOAD_OP: if (adv_evt) state_nxt = ST_EXEC;
        ST_EXEC:    state_nxt = ST_SHOW;
        ST_SHOW:    if (adv_evt) state_nxt = ST_LOAD_A;
        default:    state_nxt = ST_LOAD_A;
      endcase
    end
  end

  // Status outputs; EXEC and SHOW share code 3, told apart by op_valid.
  always_comb begin
    op_valid = (state == ST_EXEC);
    state_q  = (state == ST_SHOW) ? 2'd3 : state[1:0];
  end

  // Operand/opcode capture on advance, result capture in EXEC, wipe on clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      portA    <= '0;
      portB    <= '0;
      aluop    <= ALU_SLL;
      result_q <= '0;
      flags_q  <= '0;
    end else if (clr_evt) begin
      portA    <= '0;
      portB    <= '0;
      aluop    <= ALU_SLL;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (adv_evt) begin
        case (state)
          ST_LOAD_A:  portA <= sw_ext;
          ST_LOAD_B:  portB <= sw_ext;
          ST_LOAD_OP: aluop <= aluop_t'(sw_s[3:0]);
          default: ;
        endcase
      end
      if (state == ST_EXEC) begin
        result_q <= alu_result;
        flags_q  <= {alu_neg, alu_ovf, alu_zero};
      end
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with an event-level reference model
// and a combinational ALU stand-in.
module tb_alu_input_sequencer;
  import cpu_types_pkg::*;

  localparam int D = 4;
  localparam int S = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [17:0] sw_raw = '0;
  logic [3:0]  key_raw = 4'hF;
  logic [31:0] portA, portB, alu_result, result_q;
  aluop_t      aluop;
  logic        op_valid, alu_neg, alu_ovf, alu_zero;
  logic [2:0]  flags_q;
  logic [1:0]  state_q;

  int n_vec = 0;
  int n_bad = 0;

  alu_input_sequencer #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .CLK(CLK), .nRST(nRST), .sw_raw(sw_raw), .key_raw(key_raw),
    .portA(portA), .portB(portB), .aluop(aluop), .op_valid(op_valid),
    .alu_result(alu_result), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .result_q(result_q), .flags_q(flags_q), .state_q(state_q)
  );

  always #5 CLK = ~CLK;

  // returns {neg, ovf, zero, result}
  function automatic logic [34:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {r[31], v, (r == 32'd0), r};
  endfunction

  always_comb {alu_neg, alu_ovf, alu_zero, alu_result} = alu_f(portA, portB, aluop);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 EXEC, 4 SHOW
  int          m_st;
  logic [31:0] m_a, m_b, m_r;
  logic [3:0]  m_op;
  logic [2:0]  m_f;
  logic [1:0]  khist [S];
  logic [17:0] swhist [S];
  logic [1:0]  win [D];
  logic [1:0]  m_deb;
  logic        prev_ov = 1'b0;
  int          ov_cnt = 0;

  task automatic model_reset();
    m_st = 0; m_a = '0; m_b = '0; m_r = '0; m_op = '0; m_f = '0;
    m_deb = 2'b11;
    for (int i = 0; i < S; i++) begin khist[i] = 2'b11; swhist[i] = '1; end
    for (int i = 0; i < D; i++) win[i] = 2'b11;
  endtask

  // One clock's worth: a key event fires when the last D synchronized samples
  // all disagree with the accepted level and that level was "released".
  task automatic model_step();
    logic [1:0]  ev;
    logic [17:0] ss;
    logic [31:0] ext;
    logic        all_diff;
    ss = swhist[S-1];
    ext = {{16{ss[16]}}, ss[15:0]};
    for (int i = D-1; i > 0; i--) win[i] = win[i-1];
    win[0] = khist[S-1];
    for (int k = 0; k < 2; k++) begin
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (win[i][k] == m_deb[k]) all_diff = 1'b0;
      ev[k] = all_diff && m_deb[k];
      if (all_diff) m_deb[k] = ~m_deb[k];
    end
    if (ev[1]) begin
      m_st = 0; m_a = '0; m_b = '0; m_op = '0; m_r = '0; m_f = '0;
    end else begin
      case (m_st)
        0: if (ev[0]) begin m_a = ext; m_st = 1; end
        1: if (ev[0]) begin m_b = ext; m_st = 2; end
        2: if (ev[0]) begin m_op = ss[3:0]; m_st = 3; end
        3: begin {m_f, m_r} = alu_f(m_a, m_b, m_op); m_st = 4; end
        default: if (ev[0]) m_st = 0;
      endcase
    end
    for (int i = S-1; i > 0; i--) begin khist[i] = khist[i-1]; swhist[i] = swhist[i-1]; end
    khist[0] = key_raw[1:0];
    swhist[0] = sw_raw;
  endtask

  // Compare every cycle on the falling edge, then advance the model.
  always @(negedge CLK) begin
    if (!nRST) model_reset();
    chk("m_portA", portA, m_a);
    chk("m_portB", portB, m_b);
    chk("m_aluop", {28'd0, aluop}, {28'd0, m_op});
    chk("m_result", result_q, m_r);
    chk("m_flags", {29'd0, flags_q}, {29'd0, m_f});
    chk("m_state", {30'd0, state_q}, (m_st == 4) ? 32'd3 : m_st[31:0]);
    chk("m_op_valid", {31'd0, op_valid}, {31'd0, (m_st == 3)});
    chk("op_valid_twice", {31'd0, prev_ov & op_valid}, 32'd0);
    prev_ov = op_valid;
    if (op_valid) ov_cnt++;
    if (nRST) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic press(logic [1:0] m);
    key_raw[1:0] = ~m;
    cyc(10);
    key_raw[1:0] = 2'b11;
    cyc(10);
  endtask

  task automatic adv(logic [17:0] sw);
    sw_raw = sw;
    press(2'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int bl [11] = '{1, 2, 3, 1, 2, 1, 3, 2, 1, 2, 2};

    cyc(3);
    chk("rst_state", {30'd0, state_q}, 32'd0);
    chk("rst_portA", portA, 32'd0);
    chk("rst_result", result_q, 32'd0);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    nRST = 1'b1;
    cyc(2);

    // full sequence, with latency of the first press measured
    sw_raw = 18'h1_0005;
    key_raw[0] = 1'b0;
    lat = 0;
    while (state_q == 2'd0 && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    n_vec++;
    if (lat < S+D-1 || lat > S+D+1) begin
      n_bad++;
      $display("FAIL adv_latency: got %0d cycles expected %0d +-1", lat, S+D);
    end
    key_raw[0] = 1'b1;
    cyc(10);
    chk("seq_portA", portA, 32'hFFFF_0005);
    adv(18'h0_0003);
    chk("seq_portB", portB, 32'h0000_0003);
    ov_cnt = 0;
    adv({14'd0, ALU_ADD});
    chk("seq_state_show", {30'd0, state_q}, 32'd3);
    chk("seq_op_valid_low", {31'd0, op_valid}, 32'd0);
    chk("seq_result", result_q, 32'hFFFF_0008);
    chk("seq_flags", {29'd0, flags_q}, 32'd4);
    chk("seq_op_pulses", ov_cnt, 32'd1);
    adv(18'h0);
    chk("show_to_a", {30'd0, state_q}, 32'd0);

    // bouncing advance: only the final steady low is accepted
    sw_raw = 18'h0_0ABC;
    for (int i = 0; i < 11; i++) begin
      key_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(bl[i]);
    end
    chk("bounce_no_event", {30'd0, state_q}, 32'd0);
    key_raw[0] = 1'b0;
    cyc(10);
    chk("bounce_one_event", {30'd0, state_q}, 32'd1);
    chk("bounce_portA", portA, 32'h0000_0ABC);
    cyc(100);
    chk("hold_no_repeat", {30'd0, state_q}, 32'd1);
    key_raw[0] = 1'b1;
    cyc(10);

    // clear and advance together in LOAD_B
    press(2'b11);
    chk("clr_state", {30'd0, state_q}, 32'd0);
    chk("clr_portA", portA, 32'd0);
    chk("clr_portB", portB, 32'd0);

    // equal operands subtract to zero
    adv(18'h0_1234);
    adv(18'h0_1234);
    adv({14'd0, ALU_SUB});
    chk("zero_result", result_q, 32'd0);
    chk("zero_flags", {29'd0, flags_q}, 32'd1);
    adv(18'h0);

    // switches change every cycle; only the event-cycle value is taken
    key_raw[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sw_raw = 18'h00100 + 18'(i);
      cyc(1);
    end
    key_raw[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sw_raw = 18'h1_8000 + 18'(i * 7);
      cyc(1);
    end
    chk("sample_portA", portA, 32'h0000_0103);
    key_raw[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sw_raw = 18'h1_F000 + 18'(i * 3);
      cyc(1);
    end
    key_raw[0] = 1'b1;
    cyc(10);

    // asynchronous reset from LOAD_OP, observed before any clock edge
    chk("pre_rst_state", {30'd0, state_q}, 32'd2);
    #1;
    nRST = 1'b0;
    #1;
    chk("async_state", {30'd0, state_q}, 32'd0);
    chk("async_portA", portA, 32'd0);
    chk("async_portB", portB, 32'd0);
    cyc(2);
    nRST = 1'b1;
    cyc(3);
    adv(18'h0_0042);
    chk("post_rst_portA", portA, 32'h0000_0042);

    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
